bp_ptw_refill: RTL and testbench



---
 rtl/bp_ptw_refill.sv | 167 ++++++++++++++++
 tb/tb_bp_ptw_refill.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_ptw_refill.sv
// Sv39 page-table walker: one TLB miss in, PTE reads out, single-cycle TLB write or page-fault report back.
// Zero-wait walk costs two cycles per level plus one; miss_ready_and_o only in IDLE, PTE request held until mem_ready_and_i.
module bp_ptw_refill #(
    parameter int vtag_width_p        = 27,
    parameter int ptag_width_p        = 28,
    parameter int page_offset_width_p = 12
) (
    input  logic                                        clk_i,
    input  logic                                        reset_n_i,
    input  logic [ptag_width_p-1:0]                     base_ppn_i,
    input  logic                                        flush_i,
    input  logic                                        miss_v_i,
    output logic                                        miss_ready_and_o,
    input  logic [vtag_width_p-1:0]                     miss_vtag_i,
    input  logic                                        miss_instr_i,
    input  logic                                        miss_load_i,
    input  logic                                        miss_store_i,
    output logic                                        mem_v_o,
    input  logic                                        mem_ready_and_i,
    output logic [ptag_width_p+page_offset_width_p-1:0] mem_paddr_o,
    input  logic                                        mem_data_v_i,
    input  logic [63:0]                                 mem_data_i,
    output logic                                        w_v_o,
    output logic [vtag_width_p-1:0]                     w_vtag_o,
    output logic [ptag_width_p+7:0]                     w_entry_o,
    output logic                                        fault_v_o,
    output logic                                        fault_instr_o,
    output logic                                        fault_load_o,
    output logic                                        fault_store_o,
    output logic                                        busy_o
);
    localparam int seg_lp = 9;

    typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_WRITE, S_FAULT, S_DRAIN} state_e;

    state_e                    r_state, w_state_nxt;
    logic [1:0]                r_level;
    logic [vtag_width_p-1:0]   r_vtag;
    logic [ptag_width_p-1:0]   r_ppn;
    logic [2:0]                r_type;
    logic [ptag_width_p+7:0]   r_entry;

    logic                      w_accept, w_descend, w_leaf_hit;
    logic [seg_lp-1:0]         w_seg;
    logic [ptag_width_p-1:0]   w_pte_ppn, w_ptag;
    logic                      w_pte_v, w_pte_r, w_pte_w, w_pte_x, w_pte_u, w_pte_a, w_pte_d;
    logic                      w_leaf, w_misaligned, w_fault;
    logic                      w_unused;

    assign w_pte_v   = mem_data_i[0];
    assign w_pte_r   = mem_data_i[1];
    assign w_pte_w   = mem_data_i[2];
    assign w_pte_x   = mem_data_i[3];
    assign w_pte_u   = mem_data_i[4];
    assign w_pte_a   = mem_data_i[6];
    assign w_pte_d   = mem_data_i[7];
    assign w_pte_ppn = mem_data_i[10 +: ptag_width_p];
    assign w_unused  = ^{mem_data_i[63:10+ptag_width_p], mem_data_i[9:8], mem_data_i[5]};

    always_comb begin
        w_seg = r_vtag[0 +: seg_lp];
        if (r_level == 2'd2)
            w_seg = r_vtag[2*seg_lp +: seg_lp];
        else if (r_level == 2'd1)
            w_seg = r_vtag[seg_lp +: seg_lp];
    end

    // A superpage leaf must leave the untranslated VPN bits of its PPN clear.
    assign w_leaf       = w_pte_r | w_pte_x;
    assign w_misaligned = w_leaf & (((r_level == 2'd2) & (|w_pte_ppn[2*seg_lp-1:0]))
                                  | ((r_level == 2'd1) & (|w_pte_ppn[seg_lp-1:0])));
    assign w_fault      = ~w_pte_v | (w_pte_w & ~w_pte_r) | (w_leaf & ~w_pte_a)
                        | (~w_leaf & (r_level == 2'd0)) | w_misaligned;

    always_comb begin
        w_ptag = w_pte_ppn;
        if (r_level == 2'd2)
            w_ptag = {w_pte_ppn[ptag_width_p-1:2*seg_lp], r_vtag[2*seg_lp-1:0]};
        else if (r_level == 2'd1)
            w_ptag = {w_pte_ppn[ptag_width_p-1:seg_lp], r_vtag[seg_lp-1:0]};
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_descend   = 1'b0;
        w_leaf_hit  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (miss_v_i) begin
                    w_state_nxt = S_SEND;
                    w_accept    = 1'b1;
                end
            end
            S_SEND: begin
                if (flush_i)
                    w_state_nxt = mem_ready_and_i ? S_DRAIN : S_IDLE;
                else if (mem_ready_and_i)
                    w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (flush_i) begin
                    w_state_nxt = mem_data_v_i ? S_IDLE : S_DRAIN;
                end else if (mem_data_v_i) begin
                    if (w_fault) begin
                        w_state_nxt = S_FAULT;
                    end else if (w_leaf) begin
                        w_state_nxt = S_WRITE;
                        w_leaf_hit  = 1'b1;
                    end else begin
                        w_state_nxt = S_SEND;
                        w_descend   = 1'b1;
                    end
                end
            end
            S_WRITE, S_FAULT: w_state_nxt = S_IDLE;
            S_DRAIN: begin
                if (mem_data_v_i)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= S_IDLE;
            r_level <= 2'd0;
            r_vtag  <= '0;
            r_ppn   <= '0;
            r_type  <= 3'b000;
            r_entry <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_vtag  <= miss_vtag_i;
                r_type  <= {miss_instr_i, miss_load_i, miss_store_i};
                r_ppn   <= base_ppn_i;
                r_level <= 2'd2;
            end
            if (w_descend) begin
                r_ppn   <= w_pte_ppn;
                r_level <= r_level - 2'd1;
            end
            if (w_leaf_hit)
                r_entry <= {w_ptag, r_level == 2'd2, r_level == 2'd1,
                            w_pte_a, w_pte_d, w_pte_u, w_pte_x, w_pte_w, w_pte_r};
        end
    end

    assign miss_ready_and_o = (r_state == S_IDLE);
    assign busy_o           = (r_state != S_IDLE);
    assign mem_v_o          = (r_state == S_SEND);
    assign mem_paddr_o      = (r_state == S_SEND) ? {r_ppn, w_seg, 3'b000} : '0;
    assign w_v_o            = (r_state == S_WRITE) & ~flush_i;
    assign w_vtag_o         = r_vtag;
    assign w_entry_o        = r_entry;
    assign fault_v_o        = (r_state == S_FAULT) & ~flush_i;
    assign fault_instr_o    = fault_v_o & r_type[2];
    assign fault_load_o     = fault_v_o & r_type[1];
    assign fault_store_o    = fault_v_o & r_type[0];

    // Only one PTE read is ever outstanding, so a response is legal only while one is owed.
    assert property (@(posedge clk_i) disable iff (!reset_n_i)
        mem_data_v_i |-> (r_state == S_WAIT || r_state == S_DRAIN));

endmodule

// File: tb/tb_bp_ptw_refill.sv
// Bench for bp_ptw_refill: directed and random Sv39 walks against a queue-based reference walk.
module tb_bp_ptw_refill;
    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic [27:0] base_ppn_i;
    logic        flush_i;
    logic        miss_v_i;
    logic        miss_ready_and_o;
    logic [26:0] miss_vtag_i;
    logic        miss_instr_i, miss_load_i, miss_store_i;
    logic        mem_v_o;
    logic        mem_ready_and_i;
    logic [39:0] mem_paddr_o;
    logic        mem_data_v_i;
    logic [63:0] mem_data_i;
    logic        w_v_o;
    logic [26:0] w_vtag_o;
    logic [35:0] w_entry_o;
    logic        fault_v_o, fault_instr_o, fault_load_o, fault_store_o;
    logic        busy_o;

    bp_ptw_refill dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .base_ppn_i(base_ppn_i), .flush_i(flush_i),
        .miss_v_i(miss_v_i), .miss_ready_and_o(miss_ready_and_o), .miss_vtag_i(miss_vtag_i),
        .miss_instr_i(miss_instr_i), .miss_load_i(miss_load_i), .miss_store_i(miss_store_i),
        .mem_v_o(mem_v_o), .mem_ready_and_i(mem_ready_and_i), .mem_paddr_o(mem_paddr_o),
        .mem_data_v_i(mem_data_v_i), .mem_data_i(mem_data_i),
        .w_v_o(w_v_o), .w_vtag_o(w_vtag_o), .w_entry_o(w_entry_o),
        .fault_v_o(fault_v_o), .fault_instr_o(fault_instr_o), .fault_load_o(fault_load_o),
        .fault_store_o(fault_store_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          is_fault;
        logic [26:0] vtag;
        logic [35:0] entry;
        logic [2:0]  typ;
        int          lat;
    } resp_t;

    resp_t       exp_resp_q[$];
    logic [39:0] exp_addr_q[$];
    logic [63:0] pte_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int accept_cyc = 0;
    int ready_pct = 100;
    int dly_min = 0;
    int dly_max = 0;
    bit mon_en  = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference walk: follows the translation rules level by level with plain arithmetic.
    task automatic model_walk(input logic [27:0] base, input logic [26:0] vt, input logic [2:0] typ,
                              input logic [63:0] p2, input logic [63:0] p1, input logic [63:0] p0,
                              input bit chk_lat);
        logic [63:0] ptes[3];
        logic [27:0] ppn, pte_ppn, ptag;
        logic [63:0] pte;
        int          lvl, seg, steps;
        bit          v, r, w, x, u, a, d, leaf, bad;
        resp_t       rsp;
        ptes[0] = p2; ptes[1] = p1; ptes[2] = p0;
        ppn = base;
        lvl = 2;
        steps = 0;
        while (1) begin
            seg = int'((vt >> (9 * lvl)) % 512);
            exp_addr_q.push_back(40'(ppn) * 4096 + 40'(seg) * 8);
            pte = ptes[steps];
            pte_q.push_back(pte);
            steps++;
            v = pte[0]; r = pte[1]; w = pte[2]; x = pte[3]; u = pte[4]; a = pte[6]; d = pte[7];
            pte_ppn = 28'((pte >> 10) % (64'd1 << 28));
            leaf = r || x;
            bad = !v || (w && !r) || (leaf && !a) || (!leaf && lvl == 0)
                  || (leaf && lvl == 2 && (pte_ppn % (28'd1 << 18)) != 0)
                  || (leaf && lvl == 1 && (pte_ppn % 28'd512) != 0);
            rsp.vtag = vt;
            rsp.typ = typ;
            rsp.lat = chk_lat ? 1 + 2 * steps : -1;
            if (bad) begin
                rsp.is_fault = 1'b1;
                rsp.entry = '0;
                exp_resp_q.push_back(rsp);
                break;
            end
            if (leaf) begin
                if (lvl == 2)      ptag = ((pte_ppn >> 18) << 18) | 28'(vt % (27'd1 << 18));
                else if (lvl == 1) ptag = ((pte_ppn >> 9) << 9) | 28'(vt % 27'd512);
                else               ptag = pte_ppn;
                rsp.is_fault = 1'b0;
                rsp.entry = {ptag, lvl == 2, lvl == 1, a, d, u, x, w, r};
                exp_resp_q.push_back(rsp);
                break;
            end
            ppn = pte_ppn;
            lvl--;
        end
    endtask

    task automatic do_walk(input logic [27:0] base, input logic [26:0] vt, input logic [2:0] typ,
                           input logic [63:0] p2, input logic [63:0] p1, input logic [63:0] p0,
                           input bit chk_lat);
        int n;
        model_walk(base, vt, typ, p2, p1, p0, chk_lat);
        @(posedge clk_i); #1;
        base_ppn_i = base;
        miss_vtag_i = vt;
        {miss_instr_i, miss_load_i, miss_store_i} = typ;
        miss_v_i = 1'b1;
        @(negedge clk_i);
        n = 0;
        while (!miss_ready_and_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        accept_cyc = cyc;
        check("miss_accept", miss_ready_and_o, 1);
        @(posedge clk_i); #1;
        miss_v_i = 1'b0;
        n = 0;
        while ((exp_resp_q.size() != 0 || busy_o) && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        check("walk_done", busy_o, 0);
    endtask

    function automatic logic [63:0] rand_pte(input int lvl);
        logic [63:0] p;
        logic [27:0] ppn;
        logic [9:0]  fl;
        int          k;
        p = {$urandom, $urandom};
        ppn = p[37:10];
        fl = p[9:0];
        k = $urandom_range(0, 9);
        if (k < 5) begin
            fl = (fl & 10'h0F0) | 10'h001;
        end else if (k < 9) begin
            fl = (fl & 10'h0BE) | 10'h041;
            if (!fl[1] && !fl[3]) fl[1] = 1'b1;
            if ($urandom_range(0, 3) != 0) begin
                if (lvl == 2) ppn[17:0] = '0;
                if (lvl == 1) ppn[8:0] = '0;
            end
        end
        p[37:10] = ppn;
        p[9:0] = fl;
        return p;
    endfunction

    // Memory responder: takes a request, returns the next queued PTE after a programmable delay.
    initial begin
        bit          hs, pending;
        int          delay;
        logic [63:0] pte;
        pending = 1'b0;
        delay = 0;
        pte = '0;
        mem_ready_and_i = 1'b0;
        mem_data_v_i = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk_i);
            hs = reset_n_i && mem_v_o && mem_ready_and_i;
            @(posedge clk_i); #1;
            mem_data_v_i = 1'b0;
            if (hs) begin
                pending = 1'b1;
                delay = int'($urandom_range(dly_max, dly_min));
                pte = (pte_q.size() != 0) ? pte_q.pop_front() : 64'd0;
            end
            if (!reset_n_i) pending = 1'b0;
            if (pending) begin
                if (delay == 0) begin
                    mem_data_v_i = 1'b1;
                    mem_data_i = pte;
                    pending = 1'b0;
                end else begin
                    delay--;
                end
            end
            mem_ready_and_i = (int'($urandom_range(0, 99)) < ready_pct);
        end
    end

    // Monitor: every PTE request and every write/fault report is matched against the queues.
    always @(negedge clk_i) begin
        resp_t r;
        if (reset_n_i && mon_en) begin
            if (mem_v_o && mem_ready_and_i) begin
                if (exp_addr_q.size() == 0) fail("unexpected_mem_request");
                else check("mem_paddr", mem_paddr_o, exp_addr_q.pop_front());
            end
            if (w_v_o || fault_v_o) begin
                if (exp_resp_q.size() == 0) begin
                    fail("unexpected_write_or_fault");
                end else begin
                    r = exp_resp_q.pop_front();
                    check("resp_kind", {w_v_o, fault_v_o}, r.is_fault ? 2'b01 : 2'b10);
                    if (r.is_fault) begin
                        check("fault_type", {fault_instr_o, fault_load_o, fault_store_o}, r.typ);
                    end else begin
                        check("w_vtag", w_vtag_o, r.vtag);
                        check("w_entry", w_entry_o, r.entry);
                    end
                    if (r.lat >= 0) check("latency", cyc - accept_cyc, r.lat);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        reset_n_i = 1'b0;
        base_ppn_i = '0;
        flush_i = 1'b0;
        miss_v_i = 1'b0;
        miss_vtag_i = '0;
        {miss_instr_i, miss_load_i, miss_store_i} = 3'b000;

        @(negedge clk_i);
        check("rst_miss_ready", miss_ready_and_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_mem_v", mem_v_o, 0);
        check("rst_paddr", mem_paddr_o, 0);
        check("rst_outputs", {w_v_o, fault_v_o, fault_instr_o, fault_load_o, fault_store_o}, 0);
        check("rst_w_data", {w_vtag_o, w_entry_o}, 0);
        @(posedge clk_i); #1;
        reset_n_i = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk_i);

        // Three-level walk with zero-wait memory.
        do_walk(28'h100, 27'h0403005, 3'b010, (64'h200 << 10) | 64'h1, (64'h300 << 10) | 64'h1,
                (64'h12345 << 10) | 64'hCF, 1'b1);
        check("walk3_entry", w_entry_o, {28'h12345, 8'h37});
        // Gigapage leaf.
        do_walk(28'h0ABC, 27'h3A1ABCD, 3'b100, (64'h400000 << 10) | 64'h4B, 64'd0, 64'd0, 1'b1);
        check("giga_entry", w_entry_o, {28'h41ABCD, 8'hA5});
        // Misaligned megapage leaf, load miss.
        do_walk(28'h0777, 27'h1234567, 3'b010, (64'h900 << 10) | 64'h1, (64'h1 << 10) | 64'h43,
                64'd0, 1'b1);
        // Store miss hitting an invalid level-0 PTE.
        do_walk(28'h0055, 27'h7654321, 3'b001, (64'h5 << 10) | 64'h1, (64'h6 << 10) | 64'h1,
                64'd0, 1'b1);
        // Invalid root PTE.
        do_walk(28'h0123, 27'h0000042, 3'b100, 64'd0, 64'd0, 64'd0, 1'b1);

        // Flush while waiting for the PTE; response arrives three cycles later.
        dly_min = 3;
        dly_max = 3;
        exp_addr_q.push_back(40'h0321 * 4096 + 40'((27'h0ABCDEF >> 18) % 512) * 8);
        pte_q.push_back((64'h400000 << 10) | 64'h4B);
        @(posedge clk_i); #1;
        base_ppn_i = 28'h0321;
        miss_vtag_i = 27'h0ABCDEF;
        {miss_instr_i, miss_load_i, miss_store_i} = 3'b010;
        miss_v_i = 1'b1;
        @(posedge clk_i); #1;
        miss_v_i = 1'b0;
        @(posedge clk_i); #1;
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("drain_miss_ready", miss_ready_and_o, 0);
            check("drain_busy", busy_o, 1);
            check("drain_mem_v", mem_v_o, 0);
        end
        @(posedge clk_i); #1;
        check("drain_exit_ready", miss_ready_and_o, 1);
        check("drain_exit_busy", busy_o, 0);
        dly_min = 0;
        dly_max = 0;
        do_walk(28'h0321, 27'h0ABCDEF, 3'b010, (64'h400000 << 10) | 64'h4B, 64'd0, 64'd0, 1'b1);

        // Random walks with random request backpressure and response delay.
        ready_pct = 70;
        dly_max = 3;
        for (int i = 0; i < 40; i++) begin
            do_walk(28'($urandom), 27'($urandom), 3'b001 << $urandom_range(0, 2),
                    rand_pte(2), rand_pte(1), rand_pte(0), 1'b0);
        end

        // Asynchronous reset while a request is stalled in SEND.
        ready_pct = 0;
        dly_max = 0;
        repeat (2) @(posedge clk_i);
        #1;
        base_ppn_i = 28'h0999;
        miss_vtag_i = 27'h0000123;
        {miss_instr_i, miss_load_i, miss_store_i} = 3'b100;
        miss_v_i = 1'b1;
        @(posedge clk_i); #1;
        miss_v_i = 1'b0;
        @(negedge clk_i);
        check("send_mem_v", mem_v_o, 1);
        check("send_busy", busy_o, 1);
        #2;
        reset_n_i = 1'b0;
        #1;
        check("arst_mem_v", mem_v_o, 0);
        check("arst_busy", busy_o, 0);
        check("arst_miss_ready", miss_ready_and_o, 1);
        @(posedge clk_i); #1;
        reset_n_i = 1'b1;
        ready_pct = 100;
        repeat (2) @(posedge clk_i);
        do_walk(28'h0100, 27'h0403005, 3'b010, (64'h200 << 10) | 64'h1, (64'h300 << 10) | 64'h1,
                (64'h12345 << 10) | 64'hCF, 1'b1);

        repeat (3) @(negedge clk_i);
        check("left_addr", exp_addr_q.size(), 0);
        check("left_resp", exp_resp_q.size(), 0);
        check("left_pte", pte_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
